// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and helpers for the button conditioning slice.
package btn_pkg;
    localparam int DEFAULT_SYNC_STAGES = 2;
    function automatic int debounce_cnt_wid(input int cycles);
        return $clog2(cycles + 1);
    endfunction
    function automatic int up_idx(input int k);
        return 2 * k + 1;
    endfunction
    function automatic int down_idx(input int k);
        return 2 * k;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: single-channel synchroniser, debounce counter, level and edge pulses.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = 125000
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_nxt,
    output logic rise,
    output logic fall
);
    localparam int CW = debounce_cnt_wid(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_nxt;
    logic s, hit;
    assign s = sync[SYNC_STAGES-1];
    always_comb begin
        hit = (s != level) && (cnt == LAST);
        level_nxt = hit ? s : level;
        cnt_nxt = (s == level || hit) ? '0 : cnt + CW'(1);
    end
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            cnt <= cnt_nxt;
            level <= level_nxt;
            rise <= hit & s;
            fall <= hit & ~s;
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N-channel button conditioner with per-frame snapshot,
// sticky presses and up/down pair exclusion.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTNS          = 4,
    parameter bit BUTTON_LOW_ACTIVE = 1'b1,
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = 125000,
    parameter bit PRESS_STICKY      = 1'b1,
    parameter bit PAIR_EXCLUSIVE    = 1'b1
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btns,
    input  logic                frame_tick,
    output logic [NUM_BTNS-1:0] level,
    output logic [NUM_BTNS-1:0] rise,
    output logic [NUM_BTNS-1:0] fall,
    output logic [NUM_BTNS-1:0] frame_btns
);
    logic [NUM_BTNS-1:0] norm, level_nxt, acc, raw, snap;
    assign norm = BUTTON_LOW_ACTIVE ? ~btns : btns;
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK      (CLK),
            .rst_n    (rst_n),
            .raw      (norm[i]),
            .level    (level[i]),
            .level_nxt(level_nxt[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end
    // A rise visible on the tick cycle lands in this snapshot via the OR with rise.
    always_comb begin
        raw = level_nxt | (PRESS_STICKY ? (acc | rise) : '0);
        snap = raw;
        if (PAIR_EXCLUSIVE)
            for (int k = 0; k < NUM_BTNS / 2; k++)
                if (raw[up_idx(k)] & raw[down_idx(k)]) begin
                    snap[up_idx(k)] = 1'b0;
                    snap[down_idx(k)] = 1'b0;
                end
    end
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            acc <= '0;
            frame_btns <= '0;
        end else begin
            acc <= frame_tick ? '0 : (acc | rise);
            if (frame_tick) frame_btns <= snap;
        end
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus against a sample-window reference model.
module tb_btn_conditioner;
    localparam int NB = 4;
    localparam int SYNC = 2;
    localparam int DEB = 4;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic [NB-1:0] btns = '1;
    logic frame_tick = 1'b0;
    logic [NB-1:0] level, rise, fall, frame_btns;
    logic [NB-1:0] level2, rise2, fall2, frame_btns2;

    int n_tests = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    btn_conditioner #(
        .NUM_BTNS(NB), .BUTTON_LOW_ACTIVE(1'b1), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB), .PRESS_STICKY(1'b1), .PAIR_EXCLUSIVE(1'b1)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .btns(btns), .frame_tick(frame_tick),
        .level(level), .rise(rise), .fall(fall), .frame_btns(frame_btns)
    );

    btn_conditioner #(
        .NUM_BTNS(NB), .BUTTON_LOW_ACTIVE(1'b1), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB), .PRESS_STICKY(1'b0), .PAIR_EXCLUSIVE(1'b0)
    ) dut2 (
        .CLK(CLK), .rst_n(rst_n), .btns(btns), .frame_tick(frame_tick),
        .level(level2), .rise(rise2), .fall(fall2), .frame_btns(frame_btns2)
    );

    // Reference: s is the pressed state delayed SYNC cycles; a channel flips
    // when its last DEB samples of s all disagree with the current level.
    logic [NB-1:0] pipe [SYNC];
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_level, m_rise, m_fall, m_acc, m_frame, m_frame2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] exclude(input logic [NB-1:0] v);
        logic [NB-1:0] r = v;
        for (int k = 0; k < NB / 2; k++)
            if (v[2*k+1] && v[2*k]) begin
                r[2*k+1] = 1'b0;
                r[2*k] = 1'b0;
            end
        return r;
    endfunction

    task automatic model_edge(input logic [NB-1:0] b, input logic t, input logic r);
        logic [NB-1:0] s, lv;
        if (!r) begin
            foreach (pipe[i]) pipe[i] = '0;
            hist.delete();
            for (int i = 0; i < DEB; i++) hist.push_back('0);
            {m_level, m_rise, m_fall, m_acc, m_frame, m_frame2} = '0;
        end else begin
            s = pipe[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = ~b;
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            lv = m_level;
            for (int c = 0; c < NB; c++) begin
                bit flip = 1'b1;
                foreach (hist[j]) if (hist[j][c] == m_level[c]) flip = 1'b0;
                if (flip) lv[c] = ~m_level[c];
            end
            if (t) begin
                m_frame = exclude(lv | m_acc | m_rise);
                m_frame2 = lv;
            end
            m_acc = t ? '0 : (m_acc | m_rise);
            m_rise = lv & ~m_level;
            m_fall = ~lv & m_level;
            m_level = lv;
        end
    endtask

    task automatic step(input logic [NB-1:0] b, input logic t, input logic r);
        btns = b;
        frame_tick = t;
        rst_n = r;
        model_edge(b, t, r);
        @(posedge CLK);
        #1;
        check("level", 32'(level), 32'(m_level));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
        check("frame_btns", 32'(frame_btns), 32'(m_frame));
        check("frame_btns_plain", 32'(frame_btns2), 32'(m_frame2));
        check("level_plain", 32'(level2), 32'(m_level));
    endtask

    task automatic idle(input logic [NB-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt;
        int tmr [NB];
        logic [NB-1:0] b;
        for (int i = 0; i < 3; i++) step('1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step('1, (i % 3) == 0, 1'b1);
        cnt = 0;
        do begin
            step(4'b0111, 1'b0, 1'b1);
            cnt++;
        end while (!level[3] && cnt < 20);
        check("latency_level3", 32'(cnt), 32'd6);
        step(4'b0111, 1'b1, 1'b1);
        check("snap_up1", 32'(frame_btns), 32'b1000);
        idle('1, 10);
        step('1, 1'b1, 1'b1);
        idle(4'b1101, 3);
        idle('1, 10);
        step('1, 1'b1, 1'b1);
        check("glitch_snap", 32'(frame_btns), 32'd0);
        idle(4'b1110, 10);
        idle('1, 50);
        step('1, 1'b1, 1'b1);
        check("sticky_snap", 32'(frame_btns), 32'b0001);
        check("nonsticky_snap", 32'(frame_btns2), 32'd0);
        idle('1, 5);
        step('1, 1'b1, 1'b1);
        check("sticky_cleared", 32'(frame_btns), 32'd0);
        idle(4'b0011, 10);
        step(4'b0011, 1'b1, 1'b1);
        check("pair_excl", 32'(frame_btns[3:2]), 32'b00);
        check("pair_plain", 32'(frame_btns2[3:2]), 32'b11);
        check("pair_level", 32'(level[3:2]), 32'b11);
        idle('1, 10);
        idle(4'b1011, 10);
        step(4'b1011, 1'b1, 1'b1);
        check("snap_down1", 32'(frame_btns), 32'b0100);
        step(4'b1011, 1'b1, 1'b0);
        check("rst_frame", 32'(frame_btns), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        cnt = 0;
        do begin
            step(4'b1011, 1'b0, 1'b1);
            cnt++;
        end while (!level[2] && cnt < 20);
        check("latency_after_rst", 32'(cnt), 32'd6);
        check("frame_held_zero", 32'(frame_btns), 32'd0);
        b = '1;
        foreach (tmr[c]) tmr[c] = $urandom_range(1, 14);
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (tmr[c] == 0) begin
                    b[c] = ~b[c];
                    tmr[c] = $urandom_range(1, 14);
                end else tmr[c]--;
            end
            step(b, $urandom_range(0, 7) == 0, $urandom_range(0, 599) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
